// File: rtl/pdl_puf_eval_ctrl.sv
// rtl/pdl_puf_eval_ctrl.sv - clocked evaluation sequencer for the PDL PUF array
// Runs NUM_EVALS reset/launch/sample rounds on one PUF and majority-votes the response.
`timescale 1ns/1ps
module pdl_puf_eval_ctrl #(
  parameter int NUM_PUFS      = 16,
  parameter int CHAL_WIDTH    = 64,
  parameter int SEL_WIDTH     = 4,
  parameter int NUM_EVALS     = 7,
  parameter int RESET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = $clog2(NUM_EVALS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CHAL_WIDTH-1:0] challenge_top,
  input  logic [CHAL_WIDTH-1:0] challenge_bottom,
  input  logic [SEL_WIDTH-1:0]  puf_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  response_bit,
  output logic [CNT_W-1:0]      ones_count,
  output logic                  stable,
  output logic [CHAL_WIDTH-1:0] pdl_s_tp,
  output logic [CHAL_WIDTH-1:0] pdl_s_btm,
  output logic                  pdl_launch,
  output logic                  pdl_reset,
  input  logic [NUM_PUFS-1:0]   pdl_response
);

  localparam int PH_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [PH_W-1:0]       r_phase;
  logic [CNT_W-1:0]      r_eval;
  logic [CNT_W-1:0]      r_acc;
  logic [CNT_W-1:0]      w_acc_nx;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  w_resp_sel;
  logic                  w_sel_ok;
  logic                  w_accept;
  logic                  w_reject;
  logic                  r_err;
  logic                  r_resp;
  logic                  r_stable;
  logic [CNT_W-1:0]      r_ones;
  logic [CHAL_WIDTH-1:0] r_s_tp;
  logic [CHAL_WIDTH-1:0] r_s_btm;

  assign w_sel_ok = ({{(32-SEL_WIDTH){1'b0}}, puf_sel} < 32'(NUM_PUFS));
  assign w_acc_nx = r_acc + CNT_W'(r_sync2);

  // Select the latched PUF's arbiter output; r_sel is always in range once accepted.
  always_comb begin
    w_resp_sel = 1'b0;
    for (int i = 0; i < NUM_PUFS; i++) begin
      if (r_sel == SEL_WIDTH'(i)) w_resp_sel = pdl_response[i];
    end
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_reject   = 1'b0;
    pdl_reset  = 1'b0;
    pdl_launch = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        pdl_reset = 1'b1;
        busy      = 1'b0;
        if (start) begin
          if (w_sel_ok) begin
            w_accept = 1'b1;
            w_next   = ST_RST;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_RST: begin
        pdl_reset = 1'b1;
        if (r_phase == PH_W'(RESET_CYCLES - 1)) w_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        pdl_launch = 1'b1;
        if (r_phase == PH_W'(SETTLE_CYCLES - 1)) w_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        pdl_launch = 1'b1;
        if (r_eval == CNT_W'(NUM_EVALS - 1)) w_next = ST_DONE;
        else                                 w_next = ST_RST;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        pdl_reset = 1'b1;
        busy      = 1'b0;
        w_next    = ST_IDLE;
      end
    endcase
  end

  // Phase counter restarts on every state change so each phase length is exact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_phase <= '0;
      else                   r_phase <= r_phase + PH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= w_resp_sel;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s_tp   <= '0;
      r_s_btm  <= '0;
      r_sel    <= '0;
      r_acc    <= '0;
      r_eval   <= '0;
      r_err    <= 1'b0;
      r_ones   <= '0;
      r_resp   <= 1'b0;
      r_stable <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_s_tp  <= challenge_top;
        r_s_btm <= challenge_bottom;
        r_sel   <= puf_sel;
        r_acc   <= '0;
        r_eval  <= '0;
      end
      if (r_state == ST_SAMPLE) begin
        r_acc <= w_acc_nx;
        if (w_next == ST_RST) r_eval <= r_eval + CNT_W'(1);
        // Results are captured with the final sample so they are valid in the DONE cycle.
        if (w_next == ST_DONE) begin
          r_ones   <= w_acc_nx;
          r_resp   <= (w_acc_nx > CNT_W'(NUM_EVALS / 2));
          r_stable <= (w_acc_nx == '0) || (w_acc_nx == CNT_W'(NUM_EVALS));
        end
      end
    end
  end

  assign err          = r_err;
  assign response_bit = r_resp;
  assign ones_count   = r_ones;
  assign stable       = r_stable;
  assign pdl_s_tp     = r_s_tp;
  assign pdl_s_btm    = r_s_btm;

endmodule

// File: tb/tb_pdl_puf_eval_ctrl.sv
// tb/tb_pdl_puf_eval_ctrl.sv - directed self-checking bench for pdl_puf_eval_ctrl
// Drives a behavioural PUF that answers a per-evaluation bit pattern while launched.
`timescale 1ns/1ps
module tb_pdl_puf_eval_ctrl;

  localparam int NP = 12;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] challenge_top;
  logic [63:0] challenge_bottom;
  logic [3:0]  puf_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic        response_bit;
  logic [2:0]  ones_count;
  logic        stable;
  logic [63:0] pdl_s_tp;
  logic [63:0] pdl_s_btm;
  logic        pdl_launch;
  logic        pdl_reset;
  logic [NP-1:0] pdl_response;

  logic [3:0]  tb_sel;
  logic        tb_bit;
  int          n_vec;
  int          n_err;

  assign pdl_response = (pdl_launch && tb_bit) ? (NP'(1) << tb_sel) : '0;

  pdl_puf_eval_ctrl #(
    .NUM_PUFS(NP), .CHAL_WIDTH(64), .SEL_WIDTH(4), .NUM_EVALS(7),
    .RESET_CYCLES(4), .SETTLE_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .challenge_top(challenge_top), .challenge_bottom(challenge_bottom),
    .puf_sel(puf_sel), .busy(busy), .done(done), .err(err),
    .response_bit(response_bit), .ones_count(ones_count), .stable(stable),
    .pdl_s_tp(pdl_s_tp), .pdl_s_btm(pdl_s_btm), .pdl_launch(pdl_launch),
    .pdl_reset(pdl_reset), .pdl_response(pdl_response)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic [3:0] sel, input logic [6:0] pat,
                         input logic [63:0] ct, input logic [63:0] cb, input bit poke,
                         input logic [2:0] exp_ones, input logic exp_resp, input logic exp_stab);
    int rrun, lrun, e, lat, prot_bad, chal_bad, errs, idle_bad;
    bit seen;
    rrun = 0; lrun = 0; e = 0; lat = 0; prot_bad = 0; chal_bad = 0; errs = 0; idle_bad = 0;
    seen = 1'b0;
    tb_sel = sel; tb_bit = pat[0];
    puf_sel = sel; challenge_top = ct; challenge_bottom = cb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; challenge_top = ~ct; challenge_bottom = ~cb; puf_sel = sel ^ 4'h1;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      start = 1'b0;
      if (pdl_s_tp !== ct || pdl_s_btm !== cb) chal_bad++;
      if (pdl_reset && pdl_launch) prot_bad++;
      if (err) errs++;
      if (!busy) idle_bad++;
      if (done) begin
        if (lrun != 9) prot_bad++;
        e++; lat = cyc; seen = 1'b1;
        break;
      end
      if (pdl_reset) begin
        if (lrun > 0) begin
          if (lrun != 9) prot_bad++;
          lrun = 0; e++;
          if (e < 7) tb_bit = pat[e];
        end
        rrun++;
      end
      if (pdl_launch) begin
        if (rrun > 0) begin
          if (rrun != 4) prot_bad++;
          rrun = 0;
        end
        lrun++;
      end
      if (poke && cyc == 40) start = 1'b1;
    end
    chk("done_seen", {63'd0, seen}, 64'd1);
    chk("latency", 64'(lat), 64'd92);
    chk("eval_count", 64'(e), 64'd7);
    chk("protocol", 64'(prot_bad), 64'd0);
    chk("chal_hold", 64'(chal_bad), 64'd0);
    chk("err_quiet", 64'(errs), 64'd0);
    chk("busy_held", 64'(idle_bad), 64'd0);
    chk("ones_count", {61'd0, ones_count}, {61'd0, exp_ones});
    chk("response_bit", {63'd0, response_bit}, {63'd0, exp_resp});
    chk("stable", {63'd0, stable}, {63'd0, exp_stab});
    if (poke) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    if (poke) begin
      @(posedge clk); #1;
      chk("start_not_queued", {63'd0, busy}, 64'd0);
      chk("err_on_done_start", {63'd0, err}, 64'd0);
    end
  endtask

  initial begin
    int nl;
    bit hit;
    n_vec = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; puf_sel = '0;
    challenge_top = '0; challenge_bottom = '0; tb_sel = '0; tb_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pdl_reset", {63'd0, pdl_reset}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_launch", {63'd0, pdl_launch}, 64'd0);
    chk("rst_flags", {60'd0, done, err, response_bit, stable}, 64'd0);
    chk("rst_ones", {61'd0, ones_count}, 64'd0);
    chk("rst_chal", pdl_s_tp | pdl_s_btm, 64'd0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    run_req(4'd3, 7'b1111111, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1,
            3'd7, 1'b1, 1'b1);
    run_req(4'd0, 7'b1001101, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0,
            3'd4, 1'b1, 1'b0);
    run_req(4'd0, 7'b0010100, 64'hDEAD_BEEF_0000_FFFF, 64'h1111_2222_3333_4444, 1'b0,
            3'd2, 1'b0, 1'b0);

    puf_sel = 4'd15; challenge_top = 64'h5555; challenge_bottom = 64'hAAAA; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("oor_err", {63'd0, err}, 64'd1);
    chk("oor_busy", {63'd0, busy}, 64'd0);
    chk("oor_ones_kept", {61'd0, ones_count}, 64'd2);
    chk("oor_chal_kept", pdl_s_tp, 64'hDEAD_BEEF_0000_FFFF);
    @(posedge clk); #1;
    chk("oor_err_pulse", {63'd0, err}, 64'd0);
    chk("oor_no_done", {62'd0, done, busy}, 64'd0);

    tb_sel = 4'd3; tb_bit = 1'b1; puf_sel = 4'd3;
    challenge_top = 64'h77; challenge_bottom = 64'h88; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nl = 0; hit = 1'b0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(posedge clk); #1;
      if (pdl_launch && !pdl_reset && dut.r_phase == '0) nl++;
      if (nl == 3) begin hit = 1'b1; break; end
    end
    chk("third_launch_seen", {63'd0, hit}, 64'd1);
    #3 reset = 1'b1;
    #1;
    chk("mid_launch", {63'd0, pdl_launch}, 64'd0);
    chk("mid_pdl_reset", {63'd0, pdl_reset}, 64'd1);
    chk("mid_results", {61'd0, ones_count} | {63'd0, response_bit}, 64'd0);
    chk("mid_busy_chal", {63'd0, busy} | pdl_s_tp, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_req(4'd11, 7'b0000000, 64'hCAFE_F00D_1234_5678, 64'h8765_4321_0BAD_BEEF, 1'b0,
            3'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
